clk_ctrl_sequencer: RTL and testbench
=====================================

// Module: clk_ctrl_sequencer
// PURPOSE
//  Command-driven front end that programs ClkDivider: accepts opcode/argument commands over a
//  valid/ready channel and drives divider, pulse, option, out_enable and write_pulse.
//  Tracks pulse-mode runs to completion and counts enabled DUT clock cycles.
//  Returns one response word per command.
//  Sits between the host command decoder and ClkDivider.
// PARAMETERS
//  COUNTER_BITS        32  width of divider_o (matches ClkDivider COUNTER_BITS)
//  PULSE_CONTROL_BITS  32  width of pulse_o / run length (matches ClkDivider)
//  CYCLE_BITS          32  width of enabled-cycle counter (saturating)
// PORTS
//  clk           in   1    system clock (same clock as ClkDivider)
//  rst_n         in   1    asynchronous active-low reset
//  cmd_valid     in   1    command present
//  cmd_ready     out  1    high only in IDLE; command accepted on valid&&ready edge
//  cmd_op        in   4    opcode (see BEHAVIOUR)
//  cmd_arg       in   32   argument
//  abort         in   1    terminate an in-progress pulse run
//  rsp_valid     out  1    response present; held until rsp_ready
//  rsp_ready     in   1    response consumed
//  rsp_status    out  2    0 OK, 1 ABORTED, 2 BAD_OP
//  rsp_data      out  32   response payload
//  divider_o     out  COUNTER_BITS        to ClkDivider.divider
//  pulse_o       out  PULSE_CONTROL_BITS  to ClkDivider.pulse
//  option_o      out  1    to ClkDivider.option (0 pulse, 1 auto)
//  out_enable_o  out  1    to ClkDivider.out_enable
//  write_pulse_o out  1    to ClkDivider.write_pulse, exactly one cycle wide
// BEHAVIOUR
//  Reset: divider_o=2, pulse_o=0, option_o=0, out_enable_o=0, write_pulse_o=0, cmd_ready=0 then
//   1 in IDLE, rsp_valid=0, rsp_status=0, rsp_data=0, cycle counter=0, FSM=IDLE. Reset mid-run
//   aborts silently: no response is produced.
//  FSM: IDLE -> (accept) -> RESP | WAIT; WAIT -> RESP; RESP -> IDLE on rsp_valid&&rsp_ready.
//   rsp_valid=1 exactly in RESP; rsp_status/rsp_data stable while in RESP.
//  Opcodes (every output update happens on the accept edge E0; rsp_valid=1 from E0 onward):
//   0 NOP        : rsp_data=cmd_arg.
//   1 SET_DIV    : divider_o=cmd_arg; values 0/1 are clamped to 2; rsp_data=stored value.
//   2 SET_MODE   : option_o=cmd_arg[0]; rsp_data=cmd_arg[0].
//   3 RUN_PULSES : arg==0 -> immediate OK response with rsp_data=0, no write_pulse.
//                  Otherwise: pulse_o=arg, write_pulse_o=1 (for one cycle only), option_o=0,
//                  out_enable_o=1, and an internal PULSE_CONTROL_BITS+1 counter rem=arg+1; go
//                  to WAIT. In WAIT, rem decrements every edge. On the edge where rem reaches 0
//                  (E(arg+1), when the ClkDivider pulse counter hits 0), out_enable_o=0 and the
//                  FSM goes to RESP with OK and rsp_data=arg.
//                  abort in WAIT: out_enable_o=0 on the next edge; the FSM goes to RESP with
//                  ABORTED and rsp_data=rem-1 (pulses remaining). Abort takes priority over
//                  completion in the same cycle. abort is ignored outside WAIT.
//   4 START_AUTO : option_o=1, out_enable_o=1; OK.
//   5 STOP       : out_enable_o=0; option_o is unchanged; OK.
//   6 READ_CYCLES: rsp_data=cycle counter, zero-extended or truncated to 32 bits.
//   7 CLR_CYCLES : cycle counter=0; rsp_data=previous value.
//   8-15         : BAD_OP; no state change; rsp_data=cmd_op.
//  Cycle counter: +1 on each edge where out_enable_o==1 and (option_o==1 or FSM==WAIT).
//   Saturates at all ones. CLR_CYCLES wins over increment on the same edge.
//  Cross-port rules:
//   - option_o/divider_o/pulse_o are never written outside the accept edge.
//   - cmd_ready is low in WAIT and RESP, so no command overlaps a run.
// STRUCTURE
//  Package clk_ctrl_pkg: typedef enum op_e (4b opcodes above), enum status_e (2b),
//   enum state_e {IDLE, WAIT, RESP}, localparam MIN_DIVIDER=2.
//  Single module. Sub-module sat_counter (CYCLE_BITS, inc, clr) holds the cycle counter.
//  Instantiate with ClkDivider in the integration wrapper; not instantiated here.
// TESTING
//  1 Reset -> divider_o=2, out_enable_o=0, cmd_ready=1, rsp_valid=0.
//  2 SET_DIV arg=1 -> divider_o=2, rsp_data=2. SET_DIV arg=10 -> divider_o=10, OK.
//  3 RUN_PULSES arg=5 with ClkDivider attached ->
//     - write_pulse_o high for exactly 1 cycle;
//     - out_enable_o high for 6 cycles;
//     - exactly 5 clk_o pulses;
//     - rsp OK with rsp_data=5;
//     - READ_CYCLES -> 6.
//  4 RUN_PULSES arg=100, abort 10 cycles after accept -> rsp ABORTED, rsp_data=91,
//     out_enable_o=0 next edge; abort in IDLE has no effect.
//  5 Hold rsp_ready=0 for 20 cycles in RESP -> rsp_valid/rsp_data stable and cmd_ready=0;
//     back-to-back NOPs with rsp_ready=1 -> one response per command.
//  6 cmd_op=12 -> BAD_OP, rsp_data=12, outputs unchanged.
//     CYCLE_BITS=4 with START_AUTO for 20 cycles -> READ_CYCLES=15 (saturated).
//     Assert rst_n mid-run -> all outputs at reset values, no response.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared types for the ClkDivider command sequencer: opcodes, response
// status codes, FSM states and the smallest legal divider value.
package clk_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP         = 4'd0,
    OP_SET_DIV     = 4'd1,
    OP_SET_MODE    = 4'd2,
    OP_RUN_PULSES  = 4'd3,
    OP_START_AUTO  = 4'd4,
    OP_STOP        = 4'd5,
    OP_READ_CYCLES = 4'd6,
    OP_CLR_CYCLES  = 4'd7
  } op_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_ABORTED = 2'd1,
    STAT_BAD_OP  = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int MIN_DIVIDER = 2;

endpackage

// File: rtl/clk_ctrl_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q, count_d;

  // Next count: clear, else increment unless already at all ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/clk_ctrl_sequencer.sv
// Command front end for ClkDivider. Accepts one opcode/argument command at a
// time, updates the divider controls on the accept edge, follows pulse runs to
// completion or abort, and returns one response word per command.
module clk_ctrl_sequencer
  import clk_ctrl_pkg::*;
#(
  parameter int COUNTER_BITS       = 32,
  parameter int PULSE_CONTROL_BITS = 32,
  parameter int CYCLE_BITS         = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd_op,
  input  logic [31:0]                   cmd_arg,
  input  logic                          abort,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [1:0]                    rsp_status,
  output logic [31:0]                   rsp_data,
  output logic [COUNTER_BITS-1:0]       divider_o,
  output logic [PULSE_CONTROL_BITS-1:0] pulse_o,
  output logic                          option_o,
  output logic                          out_enable_o,
  output logic                          write_pulse_o
);

  localparam logic [PULSE_CONTROL_BITS:0] REM_ONE = {{PULSE_CONTROL_BITS{1'b0}}, 1'b1};
  localparam logic [COUNTER_BITS-1:0]     DIV_MIN = COUNTER_BITS'(MIN_DIVIDER);

  // Divider values below the minimum would stall ClkDivider, so lift them.
  function automatic logic [COUNTER_BITS-1:0] clamp_div(input logic [31:0] arg);
    logic [COUNTER_BITS-1:0] v;
    v = COUNTER_BITS'(arg);
    if (v < DIV_MIN) v = DIV_MIN;
    return v;
  endfunction

  state_e                        state_q, state_d;
  logic [COUNTER_BITS-1:0]       div_q, div_d;
  logic [PULSE_CONTROL_BITS-1:0] pulse_q, pulse_d;
  logic                          opt_q, opt_d;
  logic                          oe_q, oe_d;
  logic                          wp_q, wp_d;
  logic [PULSE_CONTROL_BITS:0]   rem_q, rem_d;
  status_e                       status_q, status_d;
  logic [31:0]                   data_q, data_d;

  logic                          accept;
  logic                          run_start;
  logic [PULSE_CONTROL_BITS-1:0] arg_pulse;
  logic                          cyc_inc, cyc_clr;
  logic [CYCLE_BITS-1:0]         cyc_cnt;

  assign accept    = cmd_valid && cmd_ready;
  assign arg_pulse = PULSE_CONTROL_BITS'(cmd_arg);
  assign run_start = (cmd_op == OP_RUN_PULSES) && (arg_pulse != '0);
  assign cyc_inc   = oe_q && (opt_q || (state_q == S_WAIT));

  sat_counter #(
    .W (CYCLE_BITS)
  ) u_cycles (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (cyc_inc),
    .clr_i   (cyc_clr),
    .count_o (cyc_cnt)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: runs park in WAIT, everything else answers immediately.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = run_start ? S_WAIT : S_RESP;
      S_WAIT:  if (abort || (rem_q == REM_ONE)) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: commands only in IDLE (and never while reset is held).
  always_comb begin
    cmd_ready = rst_n && (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
  end

  // Datapath next state: command decode on accept, run tracking in WAIT.
  always_comb begin
    div_d    = div_q;
    pulse_d  = pulse_q;
    opt_d    = opt_q;
    oe_d     = oe_q;
    wp_d     = 1'b0;
    rem_d    = rem_q;
    status_d = status_q;
    data_d   = data_q;
    cyc_clr  = 1'b0;
    if (accept) begin
      status_d = STAT_OK;
      case (cmd_op)
        OP_NOP:      data_d = cmd_arg;
        OP_SET_DIV: begin
          div_d  = clamp_div(cmd_arg);
          data_d = 32'(clamp_div(cmd_arg));
        end
        OP_SET_MODE: begin
          opt_d  = cmd_arg[0];
          data_d = {31'b0, cmd_arg[0]};
        end
        OP_RUN_PULSES: begin
          if (arg_pulse == '0) begin
            data_d = '0;
          end else begin
            // One extra count covers the edge ClkDivider spends loading.
            pulse_d = arg_pulse;
            wp_d    = 1'b1;
            opt_d   = 1'b0;
            oe_d    = 1'b1;
            rem_d   = {1'b0, arg_pulse} + REM_ONE;
          end
        end
        OP_START_AUTO: begin
          opt_d  = 1'b1;
          oe_d   = 1'b1;
          data_d = '0;
        end
        OP_STOP: begin
          oe_d   = 1'b0;
          data_d = '0;
        end
        OP_READ_CYCLES: data_d = 32'(cyc_cnt);
        OP_CLR_CYCLES: begin
          cyc_clr = 1'b1;
          data_d  = 32'(cyc_cnt);
        end
        default: begin
          status_d = STAT_BAD_OP;
          data_d   = 32'(cmd_op);
        end
      endcase
    end else if (state_q == S_WAIT) begin
      rem_d = rem_q - REM_ONE;
      if (abort) begin
        oe_d     = 1'b0;
        status_d = STAT_ABORTED;
        data_d   = 32'(rem_q - REM_ONE);
      end else if (rem_q == REM_ONE) begin
        oe_d     = 1'b0;
        status_d = STAT_OK;
        data_d   = 32'(pulse_q);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= DIV_MIN;
      pulse_q  <= '0;
      opt_q    <= 1'b0;
      oe_q     <= 1'b0;
      wp_q     <= 1'b0;
      rem_q    <= '0;
      status_q <= STAT_OK;
      data_q   <= '0;
    end else begin
      div_q    <= div_d;
      pulse_q  <= pulse_d;
      opt_q    <= opt_d;
      oe_q     <= oe_d;
      wp_q     <= wp_d;
      rem_q    <= rem_d;
      status_q <= status_d;
      data_q   <= data_d;
    end
  end

  assign divider_o     = div_q;
  assign pulse_o       = pulse_q;
  assign option_o      = opt_q;
  assign out_enable_o  = oe_q;
  assign write_pulse_o = wp_q;
  assign rsp_status    = status_q;
  assign rsp_data      = data_q;

endmodule

// File: tb/tb_clk_ctrl_sequencer.sv
// Bench for clk_ctrl_sequencer: transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_clk_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, abort, rsp_valid, rsp_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_arg, rsp_data, divider_o, pulse_o;
  logic [1:0]  rsp_status;
  logic        option_o, out_enable_o, write_pulse_o;

  // second instance with a narrow cycle counter
  logic        c4_valid, c4_ready, c4_rsp_valid, c4_rsp_ready;
  logic [3:0]  c4_op;
  logic [31:0] c4_arg, c4_rsp_data, c4_div, c4_pulse;
  logic [1:0]  c4_status;
  logic        c4_opt, c4_oe, c4_wp;

  always #5 clk = ~clk;

  clk_ctrl_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .divider_o(divider_o), .pulse_o(pulse_o), .option_o(option_o),
    .out_enable_o(out_enable_o), .write_pulse_o(write_pulse_o)
  );

  clk_ctrl_sequencer #(.CYCLE_BITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c4_valid), .cmd_ready(c4_ready),
    .cmd_op(c4_op), .cmd_arg(c4_arg), .abort(1'b0), .rsp_valid(c4_rsp_valid),
    .rsp_ready(c4_rsp_ready), .rsp_status(c4_status), .rsp_data(c4_rsp_data),
    .divider_o(c4_div), .pulse_o(c4_pulse), .option_o(c4_opt),
    .out_enable_o(c4_oe), .write_pulse_o(c4_wp)
  );

  // ---------------- reference model ----------------
  // phase: 0 waiting for a command, 1 pulse run in progress, 2 response held
  logic [31:0] m_div, m_pulse, m_data, m_cyc;
  logic        m_opt, m_oe, m_wp;
  logic [1:0]  m_st;
  int          m_phase;
  longint      m_edge, m_run_end;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_div <= 32'd2; m_pulse <= '0; m_data <= '0; m_cyc <= '0;
      m_opt <= 1'b0; m_oe <= 1'b0; m_wp <= 1'b0; m_st <= 2'd0;
      m_phase <= 0; m_edge <= 0; m_run_end <= 0;
    end else begin
      m_edge <= m_edge + 1;
      m_wp   <= 1'b0;
      if (m_oe && (m_opt || m_phase == 1) && m_cyc != 32'hFFFF_FFFF) m_cyc <= m_cyc + 32'd1;
      case (m_phase)
        0: if (cmd_valid) begin
          m_st    <= 2'd0;
          m_phase <= 2;
          case (cmd_op)
            4'd0: m_data <= cmd_arg;
            4'd1: begin
              m_div  <= (cmd_arg < 32'd2) ? 32'd2 : cmd_arg;
              m_data <= (cmd_arg < 32'd2) ? 32'd2 : cmd_arg;
            end
            4'd2: begin m_opt <= cmd_arg[0]; m_data <= {31'b0, cmd_arg[0]}; end
            4'd3: begin
              if (cmd_arg == 32'd0) m_data <= '0;
              else begin
                m_pulse <= cmd_arg; m_wp <= 1'b1; m_opt <= 1'b0; m_oe <= 1'b1;
                m_run_end <= m_edge + longint'(cmd_arg) + 1;
                m_phase <= 1;
              end
            end
            4'd4: begin m_opt <= 1'b1; m_oe <= 1'b1; m_data <= '0; end
            4'd5: begin m_oe <= 1'b0; m_data <= '0; end
            4'd6: m_data <= m_cyc;
            4'd7: begin m_data <= m_cyc; m_cyc <= '0; end
            default: begin m_st <= 2'd2; m_data <= {28'b0, cmd_op}; end
          endcase
        end
        1: if (abort) begin
          m_oe <= 1'b0; m_st <= 2'd1; m_data <= 32'(m_run_end - m_edge); m_phase <= 2;
        end else if (m_edge == m_run_end) begin
          m_oe <= 1'b0; m_st <= 2'd0; m_data <= m_pulse; m_phase <= 2;
        end
        default: if (rsp_ready) m_phase <= 0;
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int wp_total = 0, oe_total = 0, rsp_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] arg);
    int n = 0;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    chk("send_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [1:0] st, output logic [31:0] d);
    int n = 0;
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    chk("rsp_arrives", 64'(rsp_valid), 64'd1);
    st = rsp_status; d = rsp_data;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [1:0]  st;
  logic [31:0] d, hold_d;
  int          wp0, oe0, r0;

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; abort = 1'b0; rsp_ready = 1'b0;
    c4_valid = 1'b0; c4_op = '0; c4_arg = '0; c4_rsp_ready = 1'b0;

    fork
      begin
        forever begin
          @(negedge clk);
          #1;
          if (rst_n) begin
            chk("m_cmd_ready", 64'(cmd_ready), 64'(m_phase == 0));
            chk("m_rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
            chk("m_divider", 64'(divider_o), 64'(m_div));
            chk("m_pulse", 64'(pulse_o), 64'(m_pulse));
            chk("m_option", 64'(option_o), 64'(m_opt));
            chk("m_out_enable", 64'(out_enable_o), 64'(m_oe));
            chk("m_write_pulse", 64'(write_pulse_o), 64'(m_wp));
            if (m_phase == 2) begin
              chk("m_rsp_status", 64'(rsp_status), 64'(m_st));
              chk("m_rsp_data", 64'(rsp_data), 64'(m_data));
            end
            wp_total += int'(write_pulse_o);
            oe_total += int'(out_enable_o);
            if (rsp_valid && rsp_ready) rsp_total++;
          end
        end
      end
    join_none

    // reset values while reset is held
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_divider", 64'(divider_o), 64'd2);
    chk("rst_out_enable", 64'(out_enable_o), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);

    // narrow counter saturates in auto mode
    c4_rsp_ready = 1'b1;
    c4_valid = 1'b1; c4_op = 4'd4;
    @(negedge clk);
    c4_valid = 1'b0;
    repeat (20) @(negedge clk);
    c4_valid = 1'b1; c4_op = 4'd6;
    @(negedge clk);
    c4_valid = 1'b0;
    chk("sat_rsp_valid", 64'(c4_rsp_valid), 64'd1);
    chk("sat_read_cycles", 64'(c4_rsp_data), 64'd15);
    chk("sat_status", 64'(c4_status), 64'd0);
    chk("sat_ready", 64'(c4_ready), 64'd0);
    chk("sat_option", 64'(c4_opt), 64'd1);
    chk("sat_oe", 64'(c4_oe), 64'd1);
    chk("sat_div", 64'(c4_div), 64'd2);
    chk("sat_pulse", 64'(c4_pulse), 64'd0);
    chk("sat_wp", 64'(c4_wp), 64'd0);

    // divider clamp and plain write
    send(4'd1, 32'd1); get_rsp(st, d);
    chk("setdiv1_data", 64'(d), 64'd2);
    chk("setdiv1_div", 64'(divider_o), 64'd2);
    send(4'd1, 32'd10); get_rsp(st, d);
    chk("setdiv10_data", 64'(d), 64'd10);
    chk("setdiv10_status", 64'(st), 64'd0);
    chk("setdiv10_div", 64'(divider_o), 64'd10);

    // pulse run of 5
    wp0 = wp_total; oe0 = oe_total;
    send(4'd3, 32'd5);
    chk("run5_pulse_o", 64'(pulse_o), 64'd5);
    get_rsp(st, d);
    chk("run5_status", 64'(st), 64'd0);
    chk("run5_data", 64'(d), 64'd5);
    chk("run5_wp_cycles", 64'(wp_total - wp0), 64'd1);
    chk("run5_oe_cycles", 64'(oe_total - oe0), 64'd6);
    send(4'd6, 32'd0); get_rsp(st, d);
    chk("run5_read_cycles", 64'(d), 64'd6);
    send(4'd7, 32'd0); get_rsp(st, d);
    chk("clr_prev", 64'(d), 64'd6);
    send(4'd6, 32'd0); get_rsp(st, d);
    chk("clr_after", 64'(d), 64'd0);

    // abort a 100-pulse run on the 10th edge after accept
    send(4'd3, 32'd100);
    repeat (9) @(negedge clk);
    chk("abort_oe_before", 64'(out_enable_o), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_oe_after", 64'(out_enable_o), 64'd0);
    get_rsp(st, d);
    chk("abort_status", 64'(st), 64'd1);
    chk("abort_data", 64'(d), 64'd91);

    // abort in idle does nothing
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_ready", 64'(cmd_ready), 64'd1);
    chk("idle_abort_rsp", 64'(rsp_valid), 64'd0);

    // response held while rsp_ready stays low
    send(4'd0, 32'hA5A5_0001);
    hold_d = rsp_data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_data", 64'(rsp_data), 64'(hold_d));
      chk("hold_ready", 64'(cmd_ready), 64'd0);
    end
    get_rsp(st, d);
    chk("hold_final", 64'(d), 64'hA5A5_0001);

    // back-to-back NOPs, one response each
    r0 = rsp_total;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(4'd0, 32'(i + 7));
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_responses", 64'(rsp_total - r0), 64'd3);

    // illegal opcode
    send(4'd12, 32'h1234); get_rsp(st, d);
    chk("badop_status", 64'(st), 64'd2);
    chk("badop_data", 64'(d), 64'd12);
    chk("badop_div", 64'(divider_o), 64'd10);
    chk("badop_oe", 64'(out_enable_o), 64'd0);

    // auto mode, stop, counter read (model checks data)
    send(4'd4, 32'd0); get_rsp(st, d);
    repeat (5) @(negedge clk);
    send(4'd5, 32'd0); get_rsp(st, d);
    chk("stop_oe", 64'(out_enable_o), 64'd0);
    chk("stop_option", 64'(option_o), 64'd1);
    send(4'd6, 32'd0); get_rsp(st, d);
    send(4'd2, 32'd0); get_rsp(st, d);
    chk("setmode_option", 64'(option_o), 64'd0);

    // zero-length run and divider clamp from 0
    wp0 = wp_total;
    send(4'd3, 32'd0); get_rsp(st, d);
    chk("run0_status", 64'(st), 64'd0);
    chk("run0_data", 64'(d), 64'd0);
    chk("run0_wp", 64'(wp_total - wp0), 64'd0);
    send(4'd1, 32'd0); get_rsp(st, d);
    chk("setdiv0_data", 64'(d), 64'd2);

    // reset in the middle of a run
    send(4'd3, 32'd50);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_div", 64'(divider_o), 64'd2);
    chk("midrst_pulse", 64'(pulse_o), 64'd0);
    chk("midrst_oe", 64'(out_enable_o), 64'd0);
    chk("midrst_option", 64'(option_o), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
